// File: rtl/tdef_pkg.sv
// Shared datapath types for the motor-control blocks: signed word width, paired
// signed words, electrical-angle sin/cos bundle and the inverse-Park sequencer states.
package tdef_pkg;

  localparam int SYSRG_W = 16;

  typedef struct packed {
    logic signed [SYSRG_W-1:0] a;
    logic signed [SYSRG_W-1:0] b;
  } dbl_s_t;

  typedef struct packed {
    logic                      val;
    logic signed [SYSRG_W-1:0] ep_sin;
    logic signed [SYSRG_W-1:0] ep_cos;
  } epos_sincos_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4
  } ipark_st_t;

endpackage

// File: rtl/sat_add_s.sv
// Signed add/subtract of two SYSRG_W+1 operands, clamped to a SYSRG_W result.
// Purely combinational; clamp flags when the result was pinned to a rail.
module sat_add_s
  import tdef_pkg::*;
(
  input  logic signed [SYSRG_W:0]   a,
  input  logic signed [SYSRG_W:0]   b,
  input  logic                      op,
  output logic signed [SYSRG_W-1:0] y,
  output logic                      clamp
);

  localparam logic signed [SYSRG_W:0] MAX_V = {2'b00, {(SYSRG_W-1){1'b1}}};
  localparam logic signed [SYSRG_W:0] MIN_V = {2'b11, {(SYSRG_W-1){1'b0}}};

  logic signed [SYSRG_W:0] s;

  always_comb begin
    s     = op ? (a - b) : (a + b);
    y     = s[SYSRG_W-1:0];
    clamp = 1'b0;
    if (s > MAX_V) begin
      y     = MAX_V[SYSRG_W-1:0];
      clamp = 1'b1;
    end else if (s < MIN_V) begin
      y     = MIN_V[SYSRG_W-1:0];
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/inv_park_tf.sv
// Inverse Park transform (dq -> alpha/beta) on one shared multiplier over four steps.
// Latency ie->oe 5 cycles; ie while busy is dropped and latches the sticky ovr flag.
module inv_park_tf
  import tdef_pkg::*;
#(
  parameter int SHIFT = SYSRG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ie,
  input  dbl_s_t       dq_voltage,
  input  epos_sincos_t epos_sincos,
  output logic         busy,
  output logic         oe,
  output dbl_s_t       ab_voltage,
  output logic         sat,
  output logic         ovr
);

  localparam int PW = 2 * SYSRG_W;

  ipark_st_t state, state_nxt;

  logic signed [SYSRG_W-1:0] vd_r, vq_r, sin_r, cos_r;
  logic signed [SYSRG_W:0]   acc;
  logic signed [SYSRG_W-1:0] alpha_r;
  logic                      alpha_clamp;

  logic signed [SYSRG_W-1:0] mul_a, mul_b;
  logic signed [PW-1:0]      prod, prod_sh;
  logic signed [SYSRG_W:0]   prod_t;
  logic signed [SYSRG_W-1:0] sum_y;
  logic                      sum_clamp;
  logic                      unused_bits;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ie) state_nxt = M0;
      M0:      state_nxt = M1;
      M1:      state_nxt = M2;
      M2:      state_nxt = M3;
      M3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand pairing per step: Vd*cos, Vq*sin, Vd*sin, Vq*cos.
  always_comb begin
    mul_a = vd_r;
    mul_b = cos_r;
    case (state)
      M1:      begin mul_a = vq_r; mul_b = sin_r; end
      M2:      begin mul_a = vd_r; mul_b = sin_r; end
      M3:      begin mul_a = vq_r; mul_b = cos_r; end
      default: begin mul_a = vd_r; mul_b = cos_r; end
    endcase
  end

  assign prod        = PW'(mul_a) * PW'(mul_b);
  assign prod_sh     = prod >>> SHIFT;
  assign prod_t      = prod_sh[SYSRG_W:0];
  assign unused_bits = ^{epos_sincos.val, prod_sh[PW-1:SYSRG_W+1]};

  sat_add_s u_sat_add (
    .a     (acc),
    .b     (prod_t),
    .op    (state == M1),
    .y     (sum_y),
    .clamp (sum_clamp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vd_r        <= '0;
      vq_r        <= '0;
      sin_r       <= '0;
      cos_r       <= '0;
      acc         <= '0;
      alpha_r     <= '0;
      alpha_clamp <= 1'b0;
      ab_voltage  <= '0;
      oe          <= 1'b0;
      sat         <= 1'b0;
      ovr         <= 1'b0;
    end else begin
      oe  <= 1'b0;
      sat <= 1'b0;
      if (ie && state != IDLE) ovr <= 1'b1;
      case (state)
        IDLE: if (ie) begin
          vd_r  <= dq_voltage.a;
          vq_r  <= dq_voltage.b;
          sin_r <= epos_sincos.ep_sin;
          cos_r <= epos_sincos.ep_cos;
        end
        M0: acc <= prod_t;
        M1: begin
          alpha_r     <= sum_y;
          alpha_clamp <= sum_clamp;
        end
        M2: acc <= prod_t;
        M3: begin
          ab_voltage.a <= alpha_r;
          ab_voltage.b <= sum_y;
          oe           <= 1'b1;
          sat          <= alpha_clamp | sum_clamp;
        end
        default: ;
      endcase
    end
  end

endmodule
